traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Demand-actuated phase scheduler for the two-road intersection. It decides when each road receives green, based on per-road vehicle sensors, minimum/maximum green timers, yellow and all-red clearance intervals. It drives the same 3-bit per-road lamp buses and pad output-enables that go to io_out[13:8]/io_oeb[13:8] in the user project wrapper. It replaces fixed-cycle sequencing with arbitration between the two roads.

## Interface
Parameters:
- CLK_DIV, 1000: clock cycles per timer tick; must be ≥ 2.
- MIN_GREEN, 5: minimum green, in ticks.
- MAX_GREEN, 20: maximum green when the other road is waiting, in ticks; must be > MIN_GREEN.
- YELLOW_T, 3: yellow duration, in ticks.
- ALLRED_T, 2: all-red clearance, in ticks.
- WALK_T, 8: pedestrian walk duration, in ticks; used only with TRAFFIC_PED_EN.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- enable  in  1  0 = forced all-red hold.
- sensor1  in  1  vehicle present on road 1 (level, synchronous).
- sensor2  in  1  vehicle present on road 2 (level, synchronous).
- ped_req  in  1  pedestrian button pulse; present only with TRAFFIC_PED_EN.
- road1_out  out  3  {red, yellow, green}, one-hot.
- road2_out  out  3  {red, yellow, green}, one-hot.
- walk  out  1  pedestrian walk lamp; present only with TRAFFIC_PED_EN.
- io_oeb  out  6  pad output-enables, driven constant 6'b000000.
- state_o  out  3  current state encoding, for debug.

## Operation
- States: AR_INIT, G1, Y1, AR1, G2, Y2, AR2, and WALK (WALK only with TRAFFIC_PED_EN).
- Lamps by state:
  - G1: road1 = 001, road2 = 100.
  - Y1: road1 = 010, road2 = 100.
  - G2 and Y2: mirror of G1 and Y1.
  - All other states: both roads 100.
- Never both roads non-red. Lamps are registered and decoded from the state register.
- Request latches:
  - req1 sets when sensor1 = 1 while road 1 is not green; it clears on entry to G1.
  - req2 is the same for road 2 and G2.
- Transition rules (evaluated only on tick):
  - AR_INIT → G1 after ALLRED_T ticks.
  - G1 → Y1 when elapsed ≥ MIN_GREEN, req2 = 1, and (sensor1 = 0 or elapsed ≥ MAX_GREEN).
  - With req2 = 0, G1 rests indefinitely. The elapsed counter saturates at MAX_GREEN.
  - Y1 → AR1 after YELLOW_T ticks.
  - AR1 → G2 after ALLRED_T ticks.
  - G2, Y2 and AR2 follow the same rules with roads swapped; AR2 → G1.
- Tick prescaler: counts 0..CLK_DIV-1 and asserts tick on CLK_DIV-1. The prescaler and elapsed counter both clear on every state transition, so each timed state lasts exactly N×CLK_DIV cycles.
- enable = 0 forces the next state to AR_INIT, clears the prescaler, elapsed counter and request latches, and holds there. Timing resumes when enable returns to 1.
- Widths: the elapsed counter is $clog2(max of all durations + 1) bits, and the prescaler is $clog2(CLK_DIV) bits. Neither wraps.

## Timing
- Reset (async assert, sync to clock edge on deassert):
  - State = AR_INIT.
  - road1_out = road2_out = 3'b100.
  - walk = 0, io_oeb = 0, all counters and latches = 0.
- Outputs change one cycle after the state-register update (registered decode).
- Sensor inputs are sampled every cycle. A single-cycle sensor pulse on the waiting road is sufficient to latch a request.
- Simultaneous events:
  - A request arriving on the same tick the gap/max condition is evaluated is honoured on that tick.
  - If enable falls at the same edge as a tick, enable wins.

## Configuration
- TRAFFIC_PED_EN defined:
  - Adds the ped_req input, the walk output, a ped latch and the WALK state.
  - The ped latch sets on ped_req and clears on WALK entry.
  - When it is set, AR1 and AR2 exit to WALK instead of green. Both roads show red and walk = 1 for WALK_T ticks.
  - WALK then exits to the green of the road opposite the one that last had green.
- TRAFFIC_PED_EN undefined: the ped_req and walk ports and the WALK state do not exist, and behaviour is as above.

## Test plan
All scenarios use CLK_DIV = 4, MIN_GREEN = 3, MAX_GREEN = 6, YELLOW_T = 2, ALLRED_T = 1, WALK_T = 2.
- Reset, then release with enable = 1 and no sensors: both lamps 100 for 4 cycles; then road1 = 001 and it stays green indefinitely.
- In G1 past minimum green, sensor1 = 0, pulse sensor2 for one cycle:
  - Y1 (road1 = 010) on the next tick, lasting 8 cycles.
  - AR1 for 4 cycles.
  - G2 (road2 = 001); req2 cleared.
- sensor1 held at 1 with a req2 pulse at G1 entry: G1 lasts exactly 24 cycles (MAX_GREEN), then Y1.
- Drop enable mid-Y2: both lamps 100 on the next cycle and held. Raise enable: G1 appears 4 cycles later.
- Assert wb_rst_i asynchronously mid-G2: lamps return to 100 immediately, and state_o = AR_INIT.
- With TRAFFIC_PED_EN, pulse ped_req during G1 with req2 set:
  - Sequence Y1 → AR1 → WALK (walk = 1, both lamps 100, 8 cycles) → G2.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated two-road phase scheduler with min/max green, yellow and all-red clearance.
// Optional pedestrian walk phase is compiled in with the TRAFFIC_PED_EN macro.
module traffic_phase_scheduler #(
  parameter int CLK_DIV   = 1000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       enable,
  input  logic       sensor1,
  input  logic       sensor2,
`ifdef TRAFFIC_PED_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [2:0] road1_out,
  output logic [2:0] road2_out,
  output logic [5:0] io_oeb,
  output logic [2:0] state_o
);

  localparam int MAX_A = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
  localparam int MAX_B = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int EW    = $clog2(MAX_D + 1);
  localparam int PW    = $clog2(CLK_DIV);

  // Limits are stored minus one: a timed state ends on the tick that completes its Nth tick.
  localparam logic [EW-1:0] MIN_M1   = EW'(MIN_GREEN - 1);
  localparam logic [EW-1:0] MAX_M1   = EW'(MAX_GREEN - 1);
  localparam logic [EW-1:0] YEL_M1   = EW'(YELLOW_T - 1);
  localparam logic [EW-1:0] AR_M1    = EW'(ALLRED_T - 1);
  localparam logic [EW-1:0] ELAP_SAT = EW'(MAX_D);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    AR_INIT = 3'd0,
    G1      = 3'd1,
    Y1      = 3'd2,
    AR1     = 3'd3,
    G2      = 3'd4,
    Y2      = 3'd5,
    AR2     = 3'd6
`ifdef TRAFFIC_PED_EN
    , WALK  = 3'd7
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [EW-1:0] elapsed_q, elapsed_d;
  logic          req1_q, req1_d;
  logic          req2_q, req2_d;
  logic [2:0]    road1_q, road1_d;
  logic [2:0]    road2_q, road2_d;
  logic          tick;
  logic          req1_eff, req2_eff;
`ifdef TRAFFIC_PED_EN
  logic          ped_q, ped_d;
  logic          last2_q, last2_d;
  logic          walk_q, walk_d;
  logic          ped_eff;
  localparam logic [EW-1:0] WALK_M1 = EW'(WALK_T - 1);
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    tick     = (presc_q == PRE_LAST);
    // A sensor sample on this very edge counts, so a request arriving on a tick is honoured.
    req1_eff = req1_q | (sensor1 & (state_q != G1));
    req2_eff = req2_q | (sensor2 & (state_q != G2));
`ifdef TRAFFIC_PED_EN
    ped_eff  = ped_q | ped_req;
`endif

    case (state_q)
      AR_INIT: if (tick && elapsed_q >= AR_M1) state_d = G1;
      G1: if (tick && elapsed_q >= MIN_M1 && req2_eff && (!sensor1 || elapsed_q >= MAX_M1))
            state_d = Y1;
      Y1:  if (tick && elapsed_q >= YEL_M1) state_d = AR1;
      AR1: if (tick && elapsed_q >= AR_M1) begin
`ifdef TRAFFIC_PED_EN
             state_d = ped_eff ? WALK : G2;
`else
             state_d = G2;
`endif
           end
      G2: if (tick && elapsed_q >= MIN_M1 && req1_eff && (!sensor2 || elapsed_q >= MAX_M1))
            state_d = Y2;
      Y2:  if (tick && elapsed_q >= YEL_M1) state_d = AR2;
      AR2: if (tick && elapsed_q >= AR_M1) begin
`ifdef TRAFFIC_PED_EN
             state_d = ped_eff ? WALK : G1;
`else
             state_d = G1;
`endif
           end
`ifdef TRAFFIC_PED_EN
      WALK: if (tick && elapsed_q >= WALK_M1) state_d = last2_q ? G1 : G2;
`endif
      default: state_d = AR_INIT;
    endcase

    if (!enable) state_d = AR_INIT;

    if (!enable || state_d != state_q || tick) presc_d = '0;
    else                                       presc_d = presc_q + 1'b1;

    elapsed_d = elapsed_q;
    if (!enable || state_d != state_q)       elapsed_d = '0;
    else if (tick && elapsed_q != ELAP_SAT)  elapsed_d = elapsed_q + 1'b1;

    req1_d = (!enable || state_d == G1) ? 1'b0 : req1_eff;
    req2_d = (!enable || state_d == G2) ? 1'b0 : req2_eff;

`ifdef TRAFFIC_PED_EN
    ped_d   = (!enable || state_d == WALK) ? 1'b0 : ped_eff;
    last2_d = (state_d == G2) ? 1'b1 : (state_d == G1) ? 1'b0 : last2_q;
    walk_d  = (state_q == WALK);
`endif

    road1_d = LAMP_RED;
    road2_d = LAMP_RED;
    case (state_q)
      G1:      road1_d = LAMP_GRN;
      Y1:      road1_d = LAMP_YEL;
      G2:      road2_d = LAMP_GRN;
      Y2:      road2_d = LAMP_YEL;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= AR_INIT;
      presc_q   <= '0;
      elapsed_q <= '0;
      req1_q    <= 1'b0;
      req2_q    <= 1'b0;
      road1_q   <= LAMP_RED;
      road2_q   <= LAMP_RED;
`ifdef TRAFFIC_PED_EN
      ped_q     <= 1'b0;
      last2_q   <= 1'b0;
      walk_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      elapsed_q <= elapsed_d;
      req1_q    <= req1_d;
      req2_q    <= req2_d;
      road1_q   <= road1_d;
      road2_q   <= road2_d;
`ifdef TRAFFIC_PED_EN
      ped_q     <= ped_d;
      last2_q   <= last2_d;
      walk_q    <= walk_d;
`endif
    end
  end

  assign road1_out = road1_q;
  assign road2_out = road2_q;
  assign io_oeb    = 6'b000000;
  assign state_o   = state_q;
`ifdef TRAFFIC_PED_EN
  assign walk      = walk_q;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed, table-driven bench for traffic_phase_scheduler (CLK_DIV=4, MIN=3, MAX=6, Y=2, AR=1, WALK=2).
// The pedestrian sequence is included when TRAFFIC_PED_EN is defined.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] S_AR_INIT = 3'd0, S_G1 = 3'd1, S_Y1 = 3'd2, S_AR1 = 3'd3;
  localparam logic [2:0] S_G2 = 3'd4, S_Y2 = 3'd5, S_AR2 = 3'd6, S_WALK = 3'd7;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, sensor1, sensor2;
  logic [2:0] road1_out, road2_out, state_o;
  logic [5:0] io_oeb;
`ifdef TRAFFIC_PED_EN
  logic       ped_req, walk;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_scheduler #(
    .CLK_DIV(4), .MIN_GREEN(3), .MAX_GREEN(6), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(2)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .enable   (enable),
    .sensor1  (sensor1),
    .sensor2  (sensor2),
`ifdef TRAFFIC_PED_EN
    .ped_req  (ped_req),
    .walk     (walk),
`endif
    .road1_out(road1_out),
    .road2_out(road2_out),
    .io_oeb   (io_oeb),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       s1;
    logic       s2;
    int         cyc;
    logic [2:0] st;
    logic [2:0] r1;
    logic [2:0] r2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic s1, input logic s2, input int cyc,
                     input logic [2:0] st, input logic [2:0] r1, input logic [2:0] r2);
    vec_t v;
    v.en = en; v.s1 = s1; v.s2 = s2; v.cyc = cyc; v.st = st; v.r1 = r1; v.r2 = r2;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] st,
                           input logic [2:0] r1, input logic [2:0] r2);
    check({tag, " state"}, {5'd0, state_o}, {5'd0, st});
    check({tag, " road1"}, {5'd0, road1_out}, {5'd0, r1});
    check({tag, " road2"}, {5'd0, road2_out}, {5'd0, r2});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; sensor1 = 1'b0; sensor2 = 1'b0;
`ifdef TRAFFIC_PED_EN
    ped_req = 1'b0;
`endif

    // g0 = G1 entry after reset, h0 = G2 at rest, k0 = G1 entry via AR2, m0 = G1 after enable.
    add(1,0,0, 3, S_AR_INIT, R, R);
    add(1,0,0, 1, S_G1,  R, R);
    add(1,0,0, 1, S_G1,  G, R);
    add(1,0,0,39, S_G1,  G, R);
    add(1,0,1, 1, S_G1,  G, R);
    add(1,0,0, 2, S_G1,  G, R);
    add(1,0,0, 1, S_Y1,  G, R);
    add(1,0,0, 1, S_Y1,  Y, R);
    add(1,0,0, 6, S_Y1,  Y, R);
    add(1,0,0, 1, S_AR1, Y, R);
    add(1,0,0, 1, S_AR1, R, R);
    add(1,0,0, 2, S_AR1, R, R);
    add(1,0,0, 1, S_G2,  R, R);
    add(1,0,0, 1, S_G2,  R, G);
    add(1,0,0,39, S_G2,  R, G);
    add(1,1,0, 1, S_G2,  R, G);
    add(1,0,0, 3, S_Y2,  R, G);
    add(1,0,0, 1, S_Y2,  R, Y);
    add(1,0,0, 7, S_AR2, R, Y);
    add(1,0,0, 1, S_AR2, R, R);
    add(1,0,0, 3, S_G1,  R, R);
    // Sensor1 held with a req2 pulse at G1 entry: green must last the full six ticks.
    add(1,1,1, 1, S_G1,  G, R);
    add(1,1,0,11, S_G1,  G, R);
    add(1,1,0,11, S_G1,  G, R);
    add(1,1,0, 1, S_Y1,  G, R);
    add(1,1,0, 7, S_Y1,  Y, R);
    add(1,0,0, 1, S_AR1, Y, R);
    add(1,0,0, 4, S_G2,  R, R);
    add(1,0,0,11, S_G2,  R, G);
    add(1,0,0, 1, S_Y2,  R, G);
    add(1,0,0, 3, S_Y2,  R, Y);
    // Enable falls mid-Y2 on a tick edge; a sensor2 request while disabled must be discarded.
    add(0,0,0, 1, S_AR_INIT, R, Y);
    add(0,0,0, 1, S_AR_INIT, R, R);
    add(0,0,1,10, S_AR_INIT, R, R);
    add(1,0,0, 3, S_AR_INIT, R, R);
    add(1,0,0, 1, S_G1,  R, R);
    add(1,0,0, 1, S_G1,  G, R);
    add(1,0,0,39, S_G1,  G, R);

    step(3);
    check_all("reset", S_AR_INIT, R, R);
    check("reset io_oeb", {2'b00, io_oeb}, 8'h00);
`ifdef TRAFFIC_PED_EN
    check("reset walk", {7'd0, walk}, 8'h00);
`endif
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      enable  = vecs[i].en;
      sensor1 = vecs[i].s1;
      sensor2 = vecs[i].s2;
      step(vecs[i].cyc);
      check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].r1, vecs[i].r2);
    end

    // Request sampled on the very tick edge that evaluates the gap condition (now at m0+40).
    step(3);
    check("sametick pre state", {5'd0, state_o}, {5'd0, S_G1});
    sensor2 = 1'b1;
    step(1);
    sensor2 = 1'b0;
    check("sametick state", {5'd0, state_o}, {5'd0, S_Y1});

    // Bounded wait for G2, then async reset mid-G2 between clock edges.
    for (int i = 0; i < 60 && state_o != S_G2; i++) step(1);
    check("wait G2 state", {5'd0, state_o}, {5'd0, S_G2});
    step(5);
    check("midG2 road2", {5'd0, road2_out}, {5'd0, G});
    #3 rst = 1'b1;
    #1;
    check_all("async rst", S_AR_INIT, R, R);
    step(2);
    rst = 1'b0;
    step(4);
    check("post rst state", {5'd0, state_o}, {5'd0, S_G1});

`ifdef TRAFFIC_PED_EN
    // q0 = G1 entry above; walk phase between AR1 and G2.
    step(36);
    sensor2 = 1'b1; ped_req = 1'b1;
    step(1);
    sensor2 = 1'b0; ped_req = 1'b0;
    step(3);
    check("ped Y1 state", {5'd0, state_o}, {5'd0, S_Y1});
    step(8);
    check("ped AR1 state", {5'd0, state_o}, {5'd0, S_AR1});
    step(4);
    check("ped WALK state", {5'd0, state_o}, {5'd0, S_WALK});
    step(1);
    check("ped walk on", {7'd0, walk}, 8'h01);
    check_all("ped walk lamps", S_WALK, R, R);
    step(7);
    check("ped G2 state", {5'd0, state_o}, {5'd0, S_G2});
    step(1);
    check("ped walk off", {7'd0, walk}, 8'h00);
    check("ped road2 green", {5'd0, road2_out}, {5'd0, G});
`endif

    check("final io_oeb", {2'b00, io_oeb}, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
